// File: rtl/hfu_pkg.sv
// ---------------------------------------------------------------------------
// hfu_pkg
// Shared types for the hazard / forwarding unit:
//   hfu_state_e   - halt sequencing states (RUN, DRAIN, HALTED)
//   hfu_stage_t   - control bits tracked for each in-flight stage
//   hfu_sel_width - width of a forward-select code for a given stage count
// ---------------------------------------------------------------------------
package hfu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hfu_state_e;

    // The destination register number depends on the AW parameter of the
    // instantiating module, so it lives in a separate array next to this
    // entry instead of inside the struct.
    typedef struct packed {
        logic valid;
        logic wr;
        logic load;
        logic flag_wr;
    } hfu_stage_t;

    // Select code 0 means "register file"; codes 1..stages name a stage.
    function automatic int hfu_sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hfu_src_match.sv
// ---------------------------------------------------------------------------
// hfu_src_match
// Youngest-match priority encoder for one ID source operand.
// Ports:
//   src_i  - source register number read by the ID instruction
//   use_i  - the source is actually read
//   hit_i  - per stage (bit k-1 = stage k): entry is valid and writes a reg
//   dst_i  - per stage destination numbers, stage k at [(k-1)*AW +: AW]
//   sel_o  - smallest stage k whose destination matches, 0 if none
// ---------------------------------------------------------------------------
module hfu_src_match
    import hfu_pkg::*;
#(
    parameter int AW     = 4,
    parameter int STAGES = 3,
    parameter int SELW   = hfu_sel_width(STAGES)
) (
    input  logic [AW-1:0]        src_i,
    input  logic                 use_i,
    input  logic [STAGES-1:0]    hit_i,
    input  logic [STAGES*AW-1:0] dst_i,
    output logic [SELW-1:0]      sel_o
);

    // Walk from the oldest stage to the youngest so the last hit written,
    // i.e. the youngest producer, wins. R0 is hard-wired and never forwarded.
    always_comb begin
        sel_o = '0;
        if (use_i && (src_i != '0)) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (hit_i[k-1] && (dst_i[(k-1)*AW +: AW] == src_i)) begin
                    sel_o = SELW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Tracks the instructions in flight after ID, chooses forwarding sources for
// the two ID operands, detects load-use (and optionally flag) hazards, and
// sequences a HLT instruction through a drain phase into a halted state.
// Optional feature macro: HFU_FLAG_HAZARD_EN (stall a conditional branch in
// ID while the instruction in EX still writes the flags).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   id_valid                   - ID holds a real instruction
//   id_src1/2, id_use1/2       - ID source registers and their read enables
//   id_dst, id_wr              - ID destination and register-write enable
//   id_load, id_flag_wr        - ID is a load / writes flags
//   id_branch, id_hlt          - ID is a conditional branch / is HLT
//   ex_redirect                - taken branch in EX, ID is wrong-path
//   stall, flush               - hold PC and IF/ID / kill IF/ID
//   fwd_sel1/2                 - 0 = register file, k = result of stage k
//   hlt, busy                  - halted / any tracked stage valid
// ---------------------------------------------------------------------------
module hazard_fwd_unit
    import hfu_pkg::*;
#(
    parameter int AW     = 4,
    parameter int STAGES = 3,
    parameter int SELW   = hfu_sel_width(STAGES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_src1,
    input  logic [AW-1:0]   id_src2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [AW-1:0]   id_dst,
    input  logic            id_wr,
    input  logic            id_load,
    input  logic            id_flag_wr,
    input  logic            id_branch,
    input  logic            id_hlt,
    input  logic            ex_redirect,
    output logic            stall,
    output logic            flush,
    output logic [SELW-1:0] fwd_sel1,
    output logic [SELW-1:0] fwd_sel2,
    output logic            hlt,
    output logic            busy
);

    hfu_stage_t        stageCtrl_q [1:STAGES];
    hfu_stage_t        stageCtrl_d [1:STAGES];
    logic [AW-1:0]     stageDst_q  [1:STAGES];
    logic [AW-1:0]     stageDst_d  [1:STAGES];
    hfu_state_e        state_q;
    hfu_state_e        state_d;

    logic [STAGES-1:0]    stageValid;
    logic [STAGES-1:0]    stageHit;
    logic [STAGES*AW-1:0] stageDstFlat;
    logic                 inRun;
    logic                 loadUse;
    logic                 flagStall;
    logic                 acceptId;
    logic                 anyValidNext;

`ifndef HFU_FLAG_HAZARD_EN
    // Without the flag hazard these inputs have no effect on the design.
    logic unusedFlagInputs;
    assign unusedFlagInputs = id_branch ^ id_flag_wr;
`endif

    // Flatten the stage table into vectors for the operand matchers.
    always_comb begin
        stageValid   = '0;
        stageHit     = '0;
        stageDstFlat = '0;
        for (int k = 1; k <= STAGES; k++) begin
            stageValid[k-1] = stageCtrl_q[k].valid;
            stageHit[k-1]   = stageCtrl_q[k].valid & stageCtrl_q[k].wr;
            stageDstFlat[(k-1)*AW +: AW] = stageDst_q[k];
        end
    end

    hfu_src_match #(.AW(AW), .STAGES(STAGES), .SELW(SELW)) u_match1 (
        .src_i (id_src1),
        .use_i (id_use1),
        .hit_i (stageHit),
        .dst_i (stageDstFlat),
        .sel_o (fwd_sel1)
    );

    hfu_src_match #(.AW(AW), .STAGES(STAGES), .SELW(SELW)) u_match2 (
        .src_i (id_src2),
        .use_i (id_use2),
        .hit_i (stageHit),
        .dst_i (stageDstFlat),
        .sel_o (fwd_sel2)
    );

    // Hazard detection and pipeline control. A load result is not ready
    // while the load sits in EX, so forwarding from stage 1 of a load must
    // wait one cycle. A redirect kills the ID instruction, so any hazard it
    // had is moot and the stall is dropped in favour of the flush.
    always_comb begin
        inRun   = (state_q == RUN);
        loadUse = stageCtrl_q[1].load &
                  ((fwd_sel1 == SELW'(1)) | (fwd_sel2 == SELW'(1)));
`ifdef HFU_FLAG_HAZARD_EN
        flagStall = id_branch & stageCtrl_q[1].valid & stageCtrl_q[1].flag_wr;
`else
        flagStall = 1'b0;
`endif
        flush    = ex_redirect & inRun;
        stall    = ((loadUse | flagStall) & id_valid & ~flush) | ~inRun;
        acceptId = id_valid & ~stall & ~ex_redirect & inRun;
        hlt      = (state_q == HALTED);
        busy     = |stageValid;
    end

    // Stage table shift: every entry ages by one stage each cycle and the
    // oldest falls off; stage 1 takes the ID instruction or a bubble.
    always_comb begin
        stageCtrl_d[1] = '0;
        stageDst_d[1]  = '0;
        for (int k = 2; k <= STAGES; k++) begin
            stageCtrl_d[k] = stageCtrl_q[k-1];
            stageDst_d[k]  = stageDst_q[k-1];
        end
        if (acceptId) begin
            stageCtrl_d[1].valid = 1'b1;
            stageCtrl_d[1].wr    = id_wr;
            stageCtrl_d[1].load  = id_load;
`ifdef HFU_FLAG_HAZARD_EN
            stageCtrl_d[1].flag_wr = id_flag_wr;
`endif
            stageDst_d[1] = id_dst;
        end
    end

    // Halt sequencing. The accepted HLT enters the table like any other
    // instruction; the unit halts in the same cycle the table first becomes
    // empty, so the drain check looks at the next-state valids.
    always_comb begin
        anyValidNext = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            anyValidNext = anyValidNext | stageCtrl_d[k].valid;
        end
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (id_valid && id_hlt && !stall && !ex_redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!anyValidNext) begin
                    state_d = HALTED;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            for (int k = 1; k <= STAGES; k++) begin
                stageCtrl_q[k] <= '0;
                stageDst_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int k = 1; k <= STAGES; k++) begin
                stageCtrl_q[k] <= stageCtrl_d[k];
                stageDst_q[k]  <= stageDst_d[k];
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Directed bench for hazard_fwd_unit with default parameters (AW=4,
// STAGES=3). Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    localparam int AW     = 4;
    localparam int STAGES = 3;
    localparam int SELW   = $clog2(STAGES + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [AW-1:0]   id_src1;
    logic [AW-1:0]   id_src2;
    logic            id_use1;
    logic            id_use2;
    logic [AW-1:0]   id_dst;
    logic            id_wr;
    logic            id_load;
    logic            id_flag_wr;
    logic            id_branch;
    logic            id_hlt;
    logic            ex_redirect;
    logic            stall;
    logic            flush;
    logic [SELW-1:0] fwd_sel1;
    logic [SELW-1:0] fwd_sel2;
    logic            hlt;
    logic            busy;

    int errors = 0;
    int checks = 0;

    hazard_fwd_unit #(.AW(AW), .STAGES(STAGES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .id_dst      (id_dst),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_flag_wr  (id_flag_wr),
        .id_branch   (id_branch),
        .id_hlt      (id_hlt),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .flush       (flush),
        .fwd_sel1    (fwd_sel1),
        .fwd_sel2    (fwd_sel2),
        .hlt         (hlt),
        .busy        (busy)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input string field,
                            input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int eStall, input int eFlush,
                               input int eSel1, input int eSel2,
                               input int eHlt, input int eBusy);
        checkVal(tag, "stall", 8'(stall),    8'(eStall));
        checkVal(tag, "flush", 8'(flush),    8'(eFlush));
        checkVal(tag, "sel1",  8'(fwd_sel1), 8'(eSel1));
        checkVal(tag, "sel2",  8'(fwd_sel2), 8'(eSel2));
        checkVal(tag, "hlt",   8'(hlt),      8'(eHlt));
        checkVal(tag, "busy",  8'(busy),     8'(eBusy));
    endtask

    task automatic applyStimulus(input int valid, input int src1, input int src2,
                                 input int use1, input int use2, input int dst,
                                 input int wr, input int load, input int flagWr,
                                 input int branch, input int hltIn, input int redirect);
        id_valid    = 1'(valid);
        id_src1     = AW'(src1);
        id_src2     = AW'(src2);
        id_use1     = 1'(use1);
        id_use2     = 1'(use2);
        id_dst      = AW'(dst);
        id_wr       = 1'(wr);
        id_load     = 1'(load);
        id_flag_wr  = 1'(flagWr);
        id_branch   = 1'(branch);
        id_hlt      = 1'(hltIn);
        ex_redirect = 1'(redirect);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (STAGES) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Back-to-back forwarding from EX, then from stages 2 and 3
        applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0);
        checkOutput("addR3", 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0);
        checkOutput("fwdEx", 0, 0, 1, 0, 0, 1);
        tick();
        applyStimulus(1, 3, 4, 1, 1, 7, 1, 0, 0, 0, 0, 0);
        checkOutput("fwdMem", 0, 0, 2, 1, 0, 1);
        tick();
        applyStimulus(1, 3, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        checkOutput("fwdWb", 0, 0, 3, 0, 0, 1);
        tick();
        applyStimulus(1, 7, 7, 1, 0, 8, 0, 0, 0, 0, 0, 0);
        checkOutput("useGate", 0, 0, 2, 0, 0, 1);
        drain();
        checkOutput("drained", 0, 0, 0, 0, 0, 0);

        // Youngest producer wins; one bubble apart forwards from stage 2
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        tick();
        tick();
        applyStimulus(1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, 0);
        checkOutput("youngest", 0, 0, 1, 1, 0, 1);
        idle();
        tick();
        applyStimulus(1, 9, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0);
        checkOutput("bubbleApart", 0, 0, 2, 0, 0, 1);
        drain();

        // Load-use: one stall cycle, then forward from stage 2
        applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
        checkOutput("lw", 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0);
        checkOutput("loadUseNoValid", 0, 0, 1, 1, 0, 1);
        applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0);
        checkOutput("loadUse", 1, 0, 1, 1, 0, 1);
        tick();
        checkOutput("loadUseAfter", 0, 0, 2, 2, 0, 1);
        drain();

        // A load into R0 never forwards or stalls
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0);
        checkOutput("r0", 0, 0, 0, 0, 0, 1);
        drain();

        // Flag-writing ADD followed by a conditional branch
        applyStimulus(1, 1, 2, 1, 1, 2, 1, 0, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef HFU_FLAG_HAZARD_EN
        checkOutput("flagStall", 1, 0, 0, 0, 0, 1);
`else
        checkOutput("flagNoStall", 0, 0, 0, 0, 0, 1);
`endif
        tick();
        checkOutput("flagAfter", 0, 0, 0, 0, 0, 1);
        drain();

        // Redirect beats HLT in ID
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("redirect", 0, 1, 0, 0, 0, 0);
        tick();
        idle();
        checkOutput("redirectRun", 0, 0, 0, 0, 0, 0);

        // HLT behind three valid stages: halted exactly STAGES cycles later
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("hltAccept", 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("drain1", 1, 0, 0, 0, 0, 1);
        tick();
        checkOutput("drain2", 1, 0, 0, 0, 0, 1);
        tick();
        checkOutput("drain3", 1, 0, 0, 0, 0, 1);
        tick();
        checkOutput("halted", 1, 0, 0, 0, 1, 0);
        tick();
        checkOutput("haltedStay", 1, 0, 0, 0, 1, 0);
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput("resetHalted", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a drain
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drainPre", 1, 0, 2, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("resetDrain", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("afterReset", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter AW, default 4, meaning register-address width.
REQ-002 SHALL have parameter STAGES, default 3, meaning tracked in-flight stages after ID (stage 1 = EX, stage STAGES = WB); legal range 2..6.
REQ-003 SHALL have parameter SELW, default $clog2(STAGES+1), meaning the forward-select width.
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset; clk is the only clock.
REQ-006 SHALL have port id_valid  in  1  ID holds a real instruction.
REQ-007 SHALL have ports id_src1, id_src2  in  AW  ID source registers.
REQ-008 SHALL have ports id_use1, id_use2  in  1  the corresponding source is read.
REQ-009 SHALL have ports id_dst  in  AW, and id_wr  in  1, meaning ID destination and its register-write enable.
REQ-010 SHALL have ports id_load, id_flag_wr, id_branch, id_hlt  in  1  ID is a load / writes flags / is a conditional branch / is HLT.
REQ-011 SHALL have port ex_redirect  in  1  a branch in EX is taken; the ID instruction is wrong-path.
REQ-012 SHALL have ports stall, flush  out  1  hold PC and IF/ID / kill the IF/ID instruction.
REQ-013 SHALL have ports fwd_sel1, fwd_sel2  out  SELW  0 = register file; k = result of stage k.
REQ-014 SHALL have ports hlt, busy  out  1  processor halted / any tracked stage valid.

Function
REQ-015 SHALL keep per stage: valid, dst, wr, load, flag_wr.
REQ-016 SHALL shift stage k into k+1 every cycle, and drop the stage-STAGES entry.
REQ-017 SHALL load stage 1 from ID when id_valid & ~stall & ~ex_redirect & state==RUN; otherwise stage 1 SHALL load a bubble (valid=0).
REQ-018 SHALL set fwd_selN to the smallest k with valid & wr & dst==id_srcN & id_useN & id_srcN!=0, else 0.
REQ-019 SHALL make forwarding combinational from current state (0-cycle latency).
REQ-020 SHALL raise load-use stall when the selected k==1 and stage 1 load==1.
REQ-021 SHALL raise flag stall when id_branch and any stage with k<=1 has flag_wr (see REQ-031).
REQ-022 SHALL drive stall = (load-use | flag stall) & id_valid, OR'd with state!=RUN.
REQ-023 SHALL drive flush = ex_redirect & state==RUN; ex_redirect SHALL override stall, with no bubble-hold.
REQ-024 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-025 SHALL go RUN->DRAIN when id_valid & id_hlt & ~stall & ~ex_redirect; redirect in the same cycle wins and HLT is discarded.
REQ-026 SHALL go DRAIN->HALTED on the first cycle all stage valids are 0; ex_redirect SHALL be ignored in DRAIN.
REQ-027 SHALL leave HALTED only on reset; hlt=1 exactly when state==HALTED.
REQ-028 SHALL make busy the OR of all stage valids.

Reset
REQ-029 SHALL, on rst_n low asynchronously, clear all stage fields, set state RUN, and drive stall=0, flush=0, fwd_sel=0, hlt=0, busy=0 (while id_valid=0).
REQ-030 SHALL discard all in-flight tracking on reset mid-operation; no state survives.

Configuration
REQ-031 SHALL include the flag stall (REQ-021) when HFU_FLAG_HAZARD_EN is defined; when it is undefined, id_branch SHALL never cause a stall and id_flag_wr SHALL be ignored.

Structure
REQ-032 SHALL place the FSM state enum, the stage-entry struct and the select-width function in package hfu_pkg.
REQ-033 SHALL implement one sub-module, hfu_src_match (per-operand youngest-match priority encoder), instantiated twice.

Verification
REQ-034 SHALL cover: ADD R3 then ADD R4,R3,R1 back-to-back -> fwd_sel1=1, stall=0; one bubble apart -> fwd_sel1=2.
REQ-035 SHALL cover: LW R5 then ADD R6,R5,R5 -> stall=1 for exactly 1 cycle, then fwd_sel1=fwd_sel2=2.
REQ-036 SHALL cover: write to R0 in stage 1, ID reads R0 -> fwd_sel1=0, no stall.
REQ-037 SHALL cover: ex_redirect with HLT in ID -> flush=1, state stays RUN, hlt=0.
REQ-038 SHALL cover: HLT accepted with 3 valid stages -> hlt rises exactly STAGES cycles later, stall=1 throughout.
REQ-039 SHALL cover: with HFU_FLAG_HAZARD_EN, ADD then B -> 1-cycle stall; without the macro -> no stall; rst_n low mid-DRAIN -> all outputs 0 asynchronously.
